reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Board-level reset controller for the 65C02 system. Synchronizes and debounces the asynchronous reset pushbutton, synchronizes the PLL-lock signal, and releases resets in a fixed order: peripherals first, then the CPU. All downstream logic consumes its registered, glitch-free reset outputs.

Parameters:
SYNC_STAGES, 2, synchronizer depth passed to each synchronizer instance (n); total flop latency is SYNC_STAGES+1
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced button changes state
STRETCH_CYCLES, 256, minimum cycles both resets stay asserted after the lock and button conditions are satisfied
STAGE_GAP, 16, cycles between peripheral reset release and CPU reset release
CNT_W, 16, width of the shared cycle counter; must hold max(DEBOUNCE_CYCLES, STRETCH_CYCLES, STAGE_GAP)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset, driven from the top-level reset source
btn_async  in  1  reset pushbutton, active-high, asynchronous, may bounce
lock_async  in  1  PLL locked, active-high, asynchronous
wdt_kick  in  1  watchdog kick pulse from CPU I/O (used only with WATCHDOG_EN)
periph_rst  out  1  peripheral reset, active-high
cpu_rst  out  1  CPU reset, active-high
ready  out  1  high when both resets are released (state RUN)
wdt_fired  out  1  sticky watchdog-timeout flag (used only with WATCHDOG_EN)

Behaviour:
- Reset: rst is synchronous and active-high on clk. On rst=1: state=WAIT, all counters=0, btn_db=0, both synchronizer chains cleared to 0. Outputs: periph_rst=1, cpu_rst=1, ready=0, wdt_fired=0. rst takes priority over every other condition in any state.
- Synchronization: btn_async and lock_async each pass through their own synchronizer, producing btn_s and lock_s. Latency is SYNC_STAGES+1 clk edges.
- Debounce: a dedicated counter clears whenever btn_s==btn_db; otherwise it increments. When the counter reaches DEBOUNCE_CYCLES-1, btn_db<=btn_s and the counter clears. Net effect: a level change must persist DEBOUNCE_CYCLES consecutive cycles before btn_db follows it.
- Fault condition: fault = !lock_s | btn_db.
- Outputs are a Moore decode of the registered state and change on the same edge as the state.
- FSM states and transitions:
  - WAIT: periph_rst=1, cpu_rst=1. If !fault: go to STRETCH, seq counter=0.
  - STRETCH: both resets asserted. If fault: go to WAIT. Else seq counter increments; when counter==STRETCH_CYCLES-1: go to PERIPH, counter=0. Occupancy is exactly STRETCH_CYCLES cycles.
  - PERIPH: periph_rst=0, cpu_rst=1. If fault: go to WAIT. When counter==STAGE_GAP-1: go to RUN.
  - RUN: both resets 0, ready=1. If fault: go to WAIT.
- Fault latency: lock_async falling to both resets asserted takes SYNC_STAGES+2 edges. Button press to reset takes SYNC_STAGES+1+DEBOUNCE_CYCLES+1 edges.
- Simultaneous events: fault on the same cycle as a counter terminal count means fault wins and the next state is WAIT. Counters never wrap; each clears on every state entry.
- A bounce during debounce restarts that count. No partial release is possible: any return to WAIT re-runs the full STRETCH.

Optional Feature:
WATCHDOG_EN defined:
- A watchdog counter runs only in RUN and clears on wdt_kick=1 or outside RUN.
- At WDT_CYCLES-1 (localparam, 2^CNT_W-1): go to WAIT and set wdt_fired=1.
- wdt_fired is cleared only by rst.

WATCHDOG_EN undefined:
- wdt_kick is ignored, wdt_fired is tied to 0, and no watchdog counter exists.
- The port list is identical either way.

Decomposition:
- Shared package: state enum (WAIT=0, STRETCH=1, PERIPH=2, RUN=3, encoded in 2 bits) and the default timing constants.
- Sub-module: the existing d_synchronizer, instanced twice with n=SYNC_STAGES and init_value=0.
- The debounce logic stays inline.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8, STAGE_GAP=3, CNT_W=8.
1. lock_async=1, btn_async=0, rst deasserted at edge 0 -> lock_s=1 at edge 3, STRETCH at edge 4, periph_rst=0 at edge 12, cpu_rst=0 and ready=1 at edge 15.
2. In RUN, btn_async high for 2 cycles -> btn_db stays 0, resets stay deasserted.
3. In RUN, btn_async held high 20 cycles -> btn_db=1 after 3+4 edges, both resets asserted the next edge. After release plus debounce, the full sequence repeats (8 cycles STRETCH, then 3 cycles PERIPH).
4. lock_async drops at STRETCH counter=5 -> WAIT within 4 edges. When lock is restored, STRETCH lasts the full 8 cycles again.
5. rst pulsed for 1 cycle in RUN -> periph_rst=1, cpu_rst=1, ready=0 on that edge, then normal re-sequence.
6. With WATCHDOG_EN and CNT_W=8: no kick in RUN -> WAIT after 255 cycles, wdt_fired=1 until rst. Kicks every 100 cycles -> no timeout.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared state encoding, default timing constants and output decode
//    state_t      WAIT=0, STRETCH=1, PERIPH=2, RUN=3
//    DEF_*        default parameter values for reset_sequencer
//    rst_decode   maps a state to {periph_rst, cpu_rst, ready}
package reset_sequencer_pkg;

   typedef enum logic [1:0] {WAIT = 2'd0, STRETCH = 2'd1, PERIPH = 2'd2, RUN = 2'd3} state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_STRETCH_CYCLES  = 256;
   localparam int DEF_STAGE_GAP       = 16;
   localparam int DEF_CNT_W           = 16;

   function automatic logic [2:0] rst_decode(state_t s);
      return {s == WAIT || s == STRETCH, s != RUN, s == RUN};
   endfunction

endpackage

// File: rtl/d_synchronizer.sv
// d_synchronizer: n-stage synchronizer plus one output register (latency n+1 edges)
//    clk, rst   clock and synchronous active-high clear to init_value
//    d          asynchronous input
//    q          synchronized output
module d_synchronizer #(
   parameter int   n          = 2,
   parameter logic init_value = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [n:0] sr;

   always_ff @(posedge clk)
      sr <= rst ? {(n + 1){init_value}} : {sr[n-1:0], d};

   assign q = sr[n];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: board reset controller, debounced button + PLL lock, ordered release
//    clk, rst     system clock, synchronous active-high reset
//    btn_async    reset pushbutton (async, bouncing, active-high)
//    lock_async   PLL locked (async, active-high)
//    wdt_kick     watchdog kick pulse
//    periph_rst   peripheral reset, released first
//    cpu_rst      CPU reset, released STAGE_GAP cycles later
//    ready        both resets released
//    wdt_fired    sticky watchdog timeout flag
//    Macro WATCHDOG_EN adds the RUN-state watchdog; otherwise wdt_kick is ignored and wdt_fired=0.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
   parameter int STAGE_GAP       = DEF_STAGE_GAP,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_async,
   input  logic lock_async,
   input  logic wdt_kick,
   output logic periph_rst,
   output logic cpu_rst,
   output logic ready,
   output logic wdt_fired
);

   localparam logic [CNT_W-1:0] DB_END  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ST_END  = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_END = CNT_W'(STAGE_GAP - 1);

   logic btn_s, lock_s, btn_db, fault, term, wdt_to;
   logic [CNT_W-1:0] db_cnt, seq_cnt;
   state_t state, nxt_state;

   d_synchronizer #(.n(SYNC_STAGES), .init_value(1'b0)) u_btn_sync (
      .clk(clk), .rst(rst), .d(btn_async), .q(btn_s)
   );

   d_synchronizer #(.n(SYNC_STAGES), .init_value(1'b0)) u_lock_sync (
      .clk(clk), .rst(rst), .d(lock_async), .q(lock_s)
   );

   // Any sample equal to the debounced level restarts the count, so a bounce restarts it too.
   always_ff @(posedge clk)
      if (rst) begin
         db_cnt <= '0;
         btn_db <= 1'b0;
      end else if (btn_s == btn_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_END) begin
         db_cnt <= '0;
         btn_db <= btn_s;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end

   assign fault = !lock_s | btn_db;
   assign term  = seq_cnt == (state == STRETCH ? ST_END : GAP_END);

   always_comb begin
      nxt_state = state;
      if (fault) nxt_state = WAIT;
      else if (state == WAIT) nxt_state = STRETCH;
      else if (state == STRETCH && term) nxt_state = PERIPH;
      else if (state == PERIPH && term) nxt_state = RUN;
      else if (state == RUN && wdt_to) nxt_state = WAIT;
   end

   // Outputs are registered from the next state so they switch on the same edge as the state.
   always_ff @(posedge clk)
      if (rst) begin
         state                       <= WAIT;
         seq_cnt                     <= '0;
         {periph_rst, cpu_rst, ready} <= rst_decode(WAIT);
      end else begin
         state                       <= nxt_state;
         seq_cnt                     <= (nxt_state == state && (state == STRETCH || state == PERIPH)) ? seq_cnt + 1'b1 : '0;
         {periph_rst, cpu_rst, ready} <= rst_decode(nxt_state);
      end

`ifdef WATCHDOG_EN
   localparam logic [CNT_W-1:0] WDT_CYCLES = '1;
   logic [CNT_W-1:0] wdt_cnt;

   assign wdt_to = state == RUN && !wdt_kick && wdt_cnt == WDT_CYCLES - 1'b1;

   always_ff @(posedge clk)
      if (rst) begin
         wdt_cnt   <= '0;
         wdt_fired <= 1'b0;
      end else begin
         wdt_cnt   <= (state != RUN || nxt_state != RUN || wdt_kick) ? '0 : wdt_cnt + 1'b1;
         wdt_fired <= wdt_fired | (wdt_to & !fault);
      end
`else
   logic unused_kick;
   assign unused_kick = wdt_kick;
   assign wdt_to      = 1'b0;
   assign wdt_fired   = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus, run-length reference model and literal pins for reset_sequencer
module tb_reset_sequencer;

   localparam int S   = 2;
   localparam int DEB = 4;
   localparam int ST  = 8;
   localparam int GAP = 3;
   localparam int CW  = 8;
   localparam int WDT_LAST = (1 << CW) - 2;

   logic clk = 1'b0, rst, btn_async, lock_async, wdt_kick;
   logic periph_rst, cpu_rst, ready, wdt_fired;
   int   total = 0, bad = 0;

   reset_sequencer #(
      .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(ST), .STAGE_GAP(GAP), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .btn_async(btn_async), .lock_async(lock_async), .wdt_kick(wdt_kick),
      .periph_rst(periph_rst), .cpu_rst(cpu_rst), .ready(ready), .wdt_fired(wdt_fired)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: inputs pass through an (S+1)-edge delay line; the button level
   // flips after DEB consecutive differing samples; r counts consecutive fault-free edges,
   // and the release stage follows directly from r.
   logic [S:0] lh, bh;
   logic db_m, fired_m, mvalid = 1'b0, fault_m, to_m;
   int   m, r, w;

   always @(posedge clk) begin
      if (rst) begin
         lh = '0; bh = '0; db_m = 1'b0; m = 0; r = 0; w = 0; fired_m = 1'b0; mvalid = 1'b1;
      end else begin
         fault_m = !lh[S] || db_m;
         to_m    = 1'b0;
`ifdef WATCHDOG_EN
         if (r <= ST + GAP || fault_m || wdt_kick) w = 0;
         else if (w == WDT_LAST) begin to_m = 1'b1; w = 0; end
         else w++;
`endif
         if (bh[S] != db_m) begin
            m++;
            if (m == DEB) begin db_m = bh[S]; m = 0; end
         end else m = 0;
         lh = {lh[S-1:0], lock_async};
         bh = {bh[S-1:0], btn_async};
         r  = (fault_m || to_m) ? 0 : (r < 100000 ? r + 1 : r);
         if (to_m) fired_m = 1'b1;
      end
   end

   always @(negedge clk)
      if (mvalid) begin
         check("model_periph_rst", periph_rst, r <= ST);
         check("model_cpu_rst", cpu_rst, r <= ST + GAP);
         check("model_ready", ready, r > ST + GAP);
         check("model_wdt_fired", wdt_fired, fired_m);
      end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; lock_async = 1'b1; btn_async = 1'b0; wdt_kick = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_periph", periph_rst, 1'b1);
      check("reset_cpu", cpu_rst, 1'b1);
      check("reset_ready", ready, 1'b0);
      check("reset_wdt", wdt_fired, 1'b0);
      // 1: power-up release order
      tick(11); check("t1_e11_periph", periph_rst, 1'b1);
      tick(1);  check("t1_e12_periph", periph_rst, 1'b0); check("t1_e12_cpu", cpu_rst, 1'b1);
      tick(2);  check("t1_e14_cpu", cpu_rst, 1'b1);
      tick(1);  check("t1_e15_cpu", cpu_rst, 1'b0); check("t1_e15_ready", ready, 1'b1);
      // 2: short press is filtered
      tick(3); btn_async = 1'b1;
      tick(2); btn_async = 1'b0;
      tick(15); check("t2_ready", ready, 1'b1); check("t2_periph", periph_rst, 1'b0);
      // 3: long press, then full re-sequence after release
      btn_async = 1'b1;
      tick(7);  check("t3_e7_ready", ready, 1'b1);
      tick(1);  check("t3_e8_periph", periph_rst, 1'b1); check("t3_e8_cpu", cpu_rst, 1'b1);
      tick(12); btn_async = 1'b0;
      tick(15); check("t3_r15_periph", periph_rst, 1'b1);
      tick(1);  check("t3_r16_periph", periph_rst, 1'b0); check("t3_r16_cpu", cpu_rst, 1'b1);
      tick(3);  check("t3_r19_ready", ready, 1'b1);
      // 4: lock loss in RUN, then again during STRETCH (seen at count 5)
      tick(2); lock_async = 1'b0;
      tick(3); check("t4_a3_ready", ready, 1'b1);
      tick(1); check("t4_a4_periph", periph_rst, 1'b1); check("t4_a4_ready", ready, 1'b0);
      tick(1); lock_async = 1'b1;
      tick(6); lock_async = 1'b0;
      tick(4); check("t4_b10_periph", periph_rst, 1'b1);
      tick(2); check("t4_b12_periph", periph_rst, 1'b1);
      lock_async = 1'b1;
      tick(11); check("t4_c11_periph", periph_rst, 1'b1);
      tick(1);  check("t4_c12_periph", periph_rst, 1'b0);
      tick(3);  check("t4_c15_ready", ready, 1'b1);
      // 5: one-cycle rst in RUN
      tick(3); rst = 1'b1;
      tick(1); rst = 1'b0;
      check("t5_periph", periph_rst, 1'b1); check("t5_cpu", cpu_rst, 1'b1); check("t5_ready", ready, 1'b0);
      tick(14); check("t5_d15_ready", ready, 1'b0);
      tick(1);  check("t5_d16_ready", ready, 1'b1);
`ifdef WATCHDOG_EN
      // 6a: no kicks -> timeout after 255 RUN cycles
      tick(254); check("t6_run254_ready", ready, 1'b1); check("t6_run254_fired", wdt_fired, 1'b0);
      tick(1);   check("t6_timeout_ready", ready, 1'b0); check("t6_timeout_fired", wdt_fired, 1'b1);
      tick(12);  check("t6_rerun_ready", ready, 1'b1); check("t6_sticky", wdt_fired, 1'b1);
`endif
      // 6b: regular kicks keep RUN alive
      for (int i = 0; i < 7; i++) begin
         tick(99); wdt_kick = 1'b1;
         tick(1);  wdt_kick = 1'b0;
      end
      check("t6_kick_ready", ready, 1'b1);
`ifdef WATCHDOG_EN
      check("t6_kick_fired", wdt_fired, 1'b1);
`else
      check("t6_kick_fired", wdt_fired, 1'b0);
`endif
      rst = 1'b1;
      tick(1); rst = 1'b0;
      check("t6_rst_fired", wdt_fired, 1'b0);
      tick(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
